// File: rtl/noc_pkg.sv
// Shared NoC constants: packet field positions, one-hot output-port codes and
// virtual-channel buffer indices.
package noc_pkg;

    localparam int unsigned NUM_PORTS = 5;

    // Packet field map (64-bit packet)
    localparam int unsigned VC_BIT   = 63;
    localparam int unsigned XDIR_BIT = 62;
    localparam int unsigned YDIR_BIT = 61;
    localparam int unsigned HOPX_MSB = 55;
    localparam int unsigned HOPX_LSB = 52;
    localparam int unsigned HOPY_MSB = 51;
    localparam int unsigned HOPY_LSB = 48;

    // One-hot output-port codes, bit order [0] PE, [1] S, [2] N, [3] E, [4] W
    localparam logic [NUM_PORTS-1:0] PORT_NONE = 5'b00000;
    localparam logic [NUM_PORTS-1:0] PORT_PE   = 5'b00001;
    localparam logic [NUM_PORTS-1:0] PORT_S    = 5'b00010;
    localparam logic [NUM_PORTS-1:0] PORT_N    = 5'b00100;
    localparam logic [NUM_PORTS-1:0] PORT_E    = 5'b01000;
    localparam logic [NUM_PORTS-1:0] PORT_W    = 5'b10000;

    // Buffer index doubles as the VC bit a packet must carry to enter it
    localparam logic BUF_EVEN = 1'b0;
    localparam logic BUF_ODD  = 1'b1;

endpackage

// File: rtl/xy_route.sv
// Combinational XY router: picks the one-hot output port for a packet and
// decrements the hop counter of the dimension being travelled.
module xy_route
    import noc_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned HOP_W  = 4
) (
    input  logic [DATA_W-1:0]    i_pkt,
    output logic [NUM_PORTS-1:0] o_route,
    output logic [DATA_W-1:0]    o_pkt
);

    logic [HOP_W-1:0] w_hop_x;
    logic [HOP_W-1:0] w_hop_y;

    assign w_hop_x = i_pkt[HOPX_MSB:HOPX_LSB];
    assign w_hop_y = i_pkt[HOPY_MSB:HOPY_LSB];

    // X first, then Y; only the taken dimension's counter moves, so no underflow
    always_comb begin
        o_route = PORT_PE;
        o_pkt   = i_pkt;
        if (w_hop_x != '0) begin
            o_route                 = i_pkt[XDIR_BIT] ? PORT_W : PORT_E;
            o_pkt[HOPX_MSB:HOPX_LSB] = w_hop_x - HOP_W'(1);
        end else if (w_hop_y != '0) begin
            o_route                 = i_pkt[YDIR_BIT] ? PORT_S : PORT_N;
            o_pkt[HOPY_MSB:HOPY_LSB] = w_hop_y - HOP_W'(1);
        end
    end

endmodule

// File: rtl/ipctrl.sv
// Router input-port controller: accepts link packets into even/odd VC buffers,
// routes them on entry, requests an output port and frees the buffer on clear.
module ipctrl
    import noc_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned HOP_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 polarity,
    input  logic                 send_in,
    input  logic [DATA_W-1:0]    data_in,
    output logic                 ready_in,
    input  logic [NUM_PORTS-1:0] clear,
    output logic [NUM_PORTS-1:0] req,
    output logic [DATA_W-1:0]    data_out,
    output logic                 vc_err
);

    localparam int unsigned NUM_BUF = 2;

    logic [DATA_W-1:0]    r_pkt   [NUM_BUF];
    logic [NUM_PORTS-1:0] r_route [NUM_BUF];
    logic [NUM_BUF-1:0]   r_full;
    logic                 r_vc_err;

    logic                 w_wr_sel;
    logic                 w_rd_sel;
    logic                 w_accept;
    logic                 w_vc_ok;
    logic                 w_clear_hit;
    logic [NUM_PORTS-1:0] w_route;
    logic [DATA_W-1:0]    w_pkt_upd;

    // Even cycle writes ODD and presents EVEN; odd cycle the reverse.
    assign w_wr_sel = ~polarity;
    assign w_rd_sel = polarity;

    assign ready_in    = ~r_full[w_wr_sel];
    assign w_accept    = send_in & ready_in;
    assign w_vc_ok     = (data_in[VC_BIT] == w_wr_sel);
    // The write buffer is also the one presented last cycle, i.e. the clear target
    assign w_clear_hit = r_full[w_wr_sel] & (|(clear & r_route[w_wr_sel]));

    xy_route #(
        .DATA_W (DATA_W),
        .HOP_W  (HOP_W)
    ) u_xy_route (
        .i_pkt   (data_in),
        .o_route (w_route),
        .o_pkt   (w_pkt_upd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pkt[BUF_EVEN]   <= '0;
            r_pkt[BUF_ODD]    <= '0;
            r_route[BUF_EVEN] <= PORT_NONE;
            r_route[BUF_ODD]  <= PORT_NONE;
            r_full            <= '0;
            r_vc_err          <= 1'b0;
        end else begin
            // Accept needs an empty buffer, and a clear only acts on a full one
            if (w_accept && w_vc_ok) begin
                r_pkt[w_wr_sel]   <= w_pkt_upd;
                r_route[w_wr_sel] <= w_route;
                r_full[w_wr_sel]  <= 1'b1;
            end else if (w_clear_hit) begin
                r_full[w_wr_sel]  <= 1'b0;
            end
            if (w_accept && !w_vc_ok) begin
                r_vc_err <= 1'b1;
            end
        end
    end

    assign req      = r_full[w_rd_sel] ? r_route[w_rd_sel] : PORT_NONE;
    assign data_out = r_pkt[w_rd_sel];
    assign vc_err   = r_vc_err;

endmodule

// File: tb/tb_ipctrl.sv
// Directed bench for ipctrl: VC buffering, XY routing, clear handling,
// VC-mismatch drop and asynchronous reset with held packets.
module tb_ipctrl;

    logic        clk;
    logic        reset;
    logic        polarity;
    logic        send_in;
    logic [63:0] data_in;
    logic        ready_in;
    logic [4:0]  clear;
    logic [4:0]  req;
    logic [63:0] data_out;
    logic        vc_err;

    int checks = 0;
    int errors = 0;

    ipctrl #(.DATA_W(64), .HOP_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .send_in  (send_in),
        .data_in  (data_in),
        .ready_in (ready_in),
        .clear    (clear),
        .req      (req),
        .data_out (data_out),
        .vc_err   (vc_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] mk(input logic vc, input logic xd, input logic yd,
                                       input logic [3:0] hx, input logic [3:0] hy,
                                       input logic [47:0] pl);
        return {vc, xd, yd, 5'b10101, hx, hy, pl};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle: flip polarity, idle inputs, settle outputs
    task automatic next_cycle();
        @(posedge clk);
        #1;
        polarity = ~polarity;
        send_in  = 1'b0;
        clear    = 5'b0;
        data_in  = '0;
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        polarity = 1'b0;
        send_in  = 1'b0;
        data_in  = '0;
        clear    = 5'b0;
        #2;
        chk("rst_req",      64'(req), 64'd0);
        chk("rst_data_out", data_out, 64'd0);
        chk("rst_vc_err",   64'(vc_err), 64'd0);
        chk("rst_ready_p0", 64'(ready_in), 64'd1);
        polarity = 1'b1;
        #1;
        chk("rst_ready_p1", 64'(ready_in), 64'd1);
        polarity = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // C1 (even): write ODD, east two hops
        chk("c1_ready", 64'(ready_in), 64'd1);
        send_in = 1'b1;
        data_in = mk(1'b1, 1'b0, 1'b0, 4'd2, 4'd0, 48'h111);

        // C2 (odd): ODD presented; write EVEN, south three hops
        next_cycle();
        chk("c2_req_e",  64'(req), 64'(5'b01000));
        chk("c2_data",   data_out, mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 48'h111));
        chk("c2_ready",  64'(ready_in), 64'd1);
        send_in = 1'b1;
        data_in = mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 48'h222);

        // C3 (even): ODD full; EVEN presented routed S; non-matching clear on ODD
        next_cycle();
        chk("c3_ready_full", 64'(ready_in), 64'd0);
        chk("c3_req_s",      64'(req), 64'(5'b00010));
        chk("c3_data",       data_out, mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 48'h222));
        clear = 5'b00100;

        // C4 (odd): ODD still requests E; clear EVEN; blocked send is ignored
        next_cycle();
        chk("c4_req_e_again", 64'(req), 64'(5'b01000));
        chk("c4_ready_full",  64'(ready_in), 64'd0);
        clear   = 5'b00010;
        send_in = 1'b1;
        data_in = mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 48'h666);

        // C5 (even): ODD still full after wrong clear; EVEN freed; clear ODD
        next_cycle();
        chk("c5_ready_full", 64'(ready_in), 64'd0);
        chk("c5_req_none",   64'(req), 64'd0);
        chk("c5_vc_err",     64'(vc_err), 64'd0);
        clear = 5'b01000;

        // C6 (odd): ODD freed; write EVEN with zero hops
        next_cycle();
        chk("c6_req_none", 64'(req), 64'd0);
        chk("c6_ready",    64'(ready_in), 64'd1);
        send_in = 1'b1;
        data_in = mk(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 48'h333);

        // C7 (even): ODD reusable; EVEN routed PE; send wrong VC into ODD
        next_cycle();
        chk("c7_ready",   64'(ready_in), 64'd1);
        chk("c7_req_pe",  64'(req), 64'(5'b00001));
        chk("c7_data",    data_out, mk(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 48'h333));
        chk("c7_vc_err0", 64'(vc_err), 64'd0);
        send_in = 1'b1;
        data_in = mk(1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 48'h444);

        // C8 (odd): packet dropped, error raised, EVEN occupied
        next_cycle();
        chk("c8_vc_err",    64'(vc_err), 64'd1);
        chk("c8_req_none",  64'(req), 64'd0);
        chk("c8_ready_full", 64'(ready_in), 64'd0);

        // C9 (even): ODD left empty; write ODD routed west
        next_cycle();
        chk("c9_ready",  64'(ready_in), 64'd1);
        chk("c9_req_pe", 64'(req), 64'(5'b00001));
        send_in = 1'b1;
        data_in = mk(1'b1, 1'b1, 1'b0, 4'd3, 4'd5, 48'h555);

        // C10 (odd): W request, only hop_x decremented, error sticky
        next_cycle();
        chk("c10_req_w",  64'(req), 64'(5'b10000));
        chk("c10_data",   data_out, mk(1'b1, 1'b1, 1'b0, 4'd2, 4'd5, 48'h555));
        chk("c10_vc_err", 64'(vc_err), 64'd1);

        // C11 (even): both buffers full, then asynchronous reset mid-cycle
        next_cycle();
        chk("c11_ready_full", 64'(ready_in), 64'd0);
        chk("c11_req_pe",     64'(req), 64'(5'b00001));
        reset = 1'b0;
        #1;
        chk("arst_req",      64'(req), 64'd0);
        chk("arst_data_out", data_out, 64'd0);
        chk("arst_ready",    64'(ready_in), 64'd1);
        chk("arst_vc_err",   64'(vc_err), 64'd0);
        polarity = ~polarity;
        #1;
        chk("arst_req_p",   64'(req), 64'd0);
        chk("arst_ready_p", 64'(ready_in), 64'd1);
        @(negedge clk);
        reset = 1'b1;

        // Nothing owed after reset: no requests on either phase
        next_cycle();
        chk("post_req_a", 64'(req), 64'd0);
        next_cycle();
        chk("post_req_b", 64'(req), 64'd0);
        chk("post_ready", 64'(ready_in), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
